// File: rtl/ts_merge_pkg.sv
// Shared constants and state encoding for the multi-TS merge scheduler.
package ts_merge_pkg;

    localparam logic [7:0]  TS_SYNC    = 8'h47;
    localparam int unsigned TS_PKT_LEN = 188;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping modulo CH_NUM.
module rr_arbiter #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any_req
);

    logic [CH_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester after ptr wins last.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        for (int unsigned k = CH_NUM; k > 0; k--) begin
            idx = CH_W'((32'(ptr) + k) % CH_NUM);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/ts_merge_sched.sv
// Packet-granular round-robin scheduler merging per-channel TS FIFOs into one byte stream.
module ts_merge_sched
    import ts_merge_pkg::*;
#(
    parameter int unsigned CH_NUM  = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned PKT_LEN = TS_PKT_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH_NUM-1:0]   ch_en,
    input  logic [CH_NUM-1:0]   ch_pkt_rdy,
    output logic [CH_NUM-1:0]   ch_rd,
    input  logic [CH_NUM*8-1:0] ch_din,
    input  logic                out_ready,
    output logic [7:0]          ts_dout,
    output logic                ts_dout_en,
    output logic                ts_dout_sop,
    output logic [CH_W-1:0]     ts_dout_ch,
    output logic                sync_err,
    output logic                busy
);

    localparam int unsigned     CNT_W    = $clog2(PKT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);
    localparam logic [CH_W-1:0]  PTR_RST  = CH_W'(CH_NUM - 1);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              issue_q, issue_d;
    logic [CH_W-1:0]   issue_ch_q, issue_ch_d;
    logic              issue_sop_q, issue_sop_d;

    logic [CH_NUM-1:0] elig;
    logic [CH_W-1:0]   arb_grant;
    logic              arb_any;

    assign elig = ch_en & ch_pkt_rdy;

    rr_arbiter #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req     (elig),
        .ptr     (ptr_q),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            ptr_q       <= PTR_RST;
            cnt_q       <= '0;
            issue_q     <= 1'b0;
            issue_ch_q  <= '0;
            issue_sop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            issue_q     <= issue_d;
            issue_ch_q  <= issue_ch_d;
            issue_sop_q <= issue_sop_d;
        end
    end

    // Eligibility only matters in StIdle; once granted, the packet runs to completion.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        issue_d     = 1'b0;
        issue_ch_d  = issue_ch_q;
        issue_sop_d = issue_sop_q;
        ch_rd       = '0;

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    ptr_d   = arb_grant;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (out_ready) begin
                    ch_rd[grant_q] = 1'b1;
                    issue_d        = 1'b1;
                    issue_ch_d     = grant_q;
                    issue_sop_d    = (cnt_q == '0);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // FIFO data lands one cycle after the read, aligned with the registered issue info.
    assign ts_dout     = issue_q ? ch_din[8*issue_ch_q +: 8] : 8'h00;
    assign ts_dout_en  = issue_q;
    assign ts_dout_sop = issue_q & issue_sop_q;
    assign ts_dout_ch  = issue_ch_q;
    assign sync_err    = ts_dout_sop & (ts_dout != TS_SYNC);
    assign busy        = (state_q == StSend);

endmodule

// File: doc/ts_merge_sched.md
Name: ts_merge_sched

Overview:
- Packet-granular round-robin scheduler for the multi-TS merge path.
- Sits between the per-channel TS packet FIFOs, which are fed by the UDP-to-TS splitters, and the single merged TS byte stream.
- Grants one eligible channel at a time and reads exactly one 188-byte TS packet from it.
- Forwards the packet bytes with SOP and channel tags, honouring downstream backpressure and checking the 0x47 sync byte.

Parameters:
- CH_NUM, 4, number of input channels (2..16).
- CH_W, 2, width of the channel index; must be at least clog2(CH_NUM).
- PKT_LEN, 188, bytes per TS packet.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ch_en  in  CH_NUM  per-channel enable; sampled only at grant time.
- ch_pkt_rdy  in  CH_NUM  channel FIFO holds at least one complete packet.
- ch_rd  out  CH_NUM  one-hot read strobe to the granted channel FIFO.
- ch_din  in  CH_NUM*8  FIFO data; channel i on bits [8i+7:8i]; valid 1 cycle after ch_rd[i].
- out_ready  in  1  downstream can take a byte issued this cycle; the byte arrives next cycle.
- ts_dout  out  8  merged TS byte.
- ts_dout_en  out  1  ts_dout valid.
- ts_dout_sop  out  1  first byte of a packet; qualified by ts_dout_en.
- ts_dout_ch  out  CH_W  source channel of the current byte.
- sync_err  out  1  one-cycle pulse: the first byte of a packet was not 0x47.
- busy  out  1  scheduler is in the SEND state.

Behaviour:
- Reset, asynchronous while rst=0:
  - ch_rd=0, ts_dout=0, ts_dout_en=0, ts_dout_sop=0, ts_dout_ch=0, sync_err=0, busy=0.
  - State=IDLE, byte counter=0, RR pointer=CH_NUM-1, so channel 0 has first priority.
- Eligibility: elig[i] = ch_en[i] & ch_pkt_rdy[i].
- FSM has two states, IDLE and SEND.
- IDLE:
  - If any elig bit is set, register grant = first eligible index searching ptr+1, ptr+2, ... modulo CH_NUM.
  - In the same edge: ptr <= grant, byte counter <= 0, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - ch_rd = onehot(grant) & {CH_NUM{out_ready}}, combinational from registered state.
  - The byte counter increments on each issued read.
  - When the read with counter==PKT_LEN-1 is issued, go to IDLE.
  - Consequence: at least one idle read cycle between packets.
- Output pipeline, 1 cycle:
  - The cycle after ch_rd[g]=1: ts_dout_en=1, ts_dout=ch_din[g] and ts_dout_ch=g, taken from the registered issue info.
  - ts_dout_sop=1 iff the issued counter was 0.
  - sync_err pulses together with an SOP byte when that byte is not 0x47. The byte is still forwarded; no resync.
- Backpressure:
  - out_ready=0 holds ch_rd low and freezes the counter.
  - A read already issued always produces ts_dout_en on the next cycle, so downstream needs 1 entry of slack.
- Mid-packet events are ignored until the packet completes:
  - ch_en or ch_pkt_rdy deasserting on the granted channel.
  - Any request from other channels.
- Single eligible channel: it is re-granted every packet, with a 1-cycle gap.
- Simultaneous requests: strict rotation with a fairness bound of CH_NUM packets.
- busy = (state==SEND).
- Reset asserted mid-packet: abort immediately to reset values. A partial packet is not completed.

Decomposition:
- Package ts_merge_pkg holds:
  - TS_SYNC = 8'h47.
  - TS_PKT_LEN = 188.
  - State encoding: IDLE=1'b0, SEND=1'b1.
- One sub-module, rr_arbiter (CH_NUM, CH_W):
  - Inputs: req vector and pointer.
  - Outputs: grant index and any_req.
  - Purely combinational; the pointer register stays in the top module.

Test Plan:
- Reset check: release rst at 100 ns, all elig=0 -> all outputs 0, busy=0, no ch_rd for 1000 cycles.
- Single channel: only ch2 rdy, data 0x47,0x10,0x01,cc then 1..184, out_ready=1:
  - ts_dout_en runs 188 consecutive cycles starting 2 cycles after the rdy sample.
  - sop on byte 0x47, ts_dout_ch=2, sync_err=0.
- Round-robin: ch0..ch3 all rdy continuously:
  - Grant order is 0,1,2,3,0.
  - Each burst is exactly 188 bytes; ts_dout_en is low exactly 1 cycle between bursts.
- Backpressure: drop out_ready for 5 cycles at byte 100:
  - ch_rd is low for those 5 cycles.
  - Exactly one more byte is delivered after the drop.
  - Total is still 188 bytes with no duplication; the byte sequence is intact.
- Mid-packet changes: deassert ch_en[1] and ch_pkt_rdy[1] at byte 50 of a ch1 packet:
  - The packet completes all 188 bytes.
  - ch1 is not granted afterwards.
- Sync error and reset: first byte 0x48 -> sync_err=1 for one cycle aligned with sop. Then assert rst at byte 30 -> all outputs 0 immediately, and after release arbitration restarts at channel 0.
